clkdiv_tick_scheduler: RTL

- Shared prescaler on clk_100M plus NUM_CH programmable channel dividers.
- Each channel produces one-cycle clock-enable strobes and, optionally, a square wave.
- Replaces free-running counter-bit clock taps with synchronous enables.
- Consumers are display scan, debounce and slow-blink logic. Channel divisors are configured at run time through a valid/ready write port.

---
 rtl/clkdiv_tick_scheduler.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/clkdiv_tick_scheduler.sv
// Shared prescaler on clk_100M feeding NUM_CH programmable tick dividers with a valid/ready config port.
// Square-wave outputs are built only when CLKDIV_SQ_OUT_EN is defined; otherwise sq_out is tied low.
module clkdiv_tick_scheduler #(
  parameter int NUM_CH   = 4,
  parameter int PRESCALE = 100,
  parameter int DIV_W    = 16,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_100M,
  input  logic              clr_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              resync,
  output logic              base_tick,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] sq_out
);

  localparam int PRE_W = $clog2(PRESCALE);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  typedef enum logic {IDLE, PEND} state_t;

  state_t            state_q, state_d;
  logic [PRE_W-1:0]  pre_q;
  logic              wrap;
  logic              accept;
  logic              apply;
  logic [CH_W-1:0]   shadow_ch;
  logic [DIV_W-1:0]  shadow_div;

  // resync outranks a wrap landing on the same edge, so nothing downstream sees that wrap
  assign wrap = (pre_q == PRE_LAST) && !resync;

  always_ff @(posedge clk_100M or negedge clr_n) begin
    if (!clr_n) begin
      pre_q     <= '0;
      base_tick <= 1'b0;
    end else if (resync) begin
      pre_q     <= '0;
      base_tick <= 1'b0;
    end else begin
      pre_q     <= wrap ? '0 : pre_q + PRE_W'(1);
      base_tick <= wrap;
    end
  end

  always_ff @(posedge clk_100M or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    accept    = 1'b0;
    apply     = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          accept  = 1'b1;
          state_d = PEND;
        end
      end
      PEND: begin
        if (wrap) begin
          apply   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_100M or negedge clr_n) begin
    if (!clr_n) begin
      shadow_ch  <= '0;
      shadow_div <= '0;
    end else if (accept) begin
      shadow_ch  <= cfg_ch;
      shadow_div <= cfg_div;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic             tick_q;
    logic             sel;
    logic             hit;

    // an out-of-range shadow_ch never matches any channel, so such writes simply vanish
    assign sel = apply && (shadow_ch == CH_W'(i));
    assign hit = (div_q != '0) && (cnt_q == div_q - DIV_W'(1));

    always_ff @(posedge clk_100M or negedge clr_n) begin
      if (!clr_n) begin
        div_q  <= '0;
        cnt_q  <= '0;
        tick_q <= 1'b0;
      end else begin
        tick_q <= 1'b0;
        if (resync) begin
          cnt_q <= '0;
        end else if (sel) begin
          div_q <= shadow_div;
          cnt_q <= '0;
        end else if (wrap && (div_q != '0)) begin
          if (hit) begin
            cnt_q  <= '0;
            tick_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + DIV_W'(1);
          end
        end
      end
    end

    assign tick[i] = tick_q;

`ifdef CLKDIV_SQ_OUT_EN
    logic sq_q;

    always_ff @(posedge clk_100M or negedge clr_n) begin
      if (!clr_n) begin
        sq_q <= 1'b0;
      end else if (resync || sel || (div_q == '0)) begin
        sq_q <= 1'b0;
      end else if (wrap && hit) begin
        sq_q <= ~sq_q;
      end
    end

    assign sq_out[i] = sq_q;
`else
    assign sq_out[i] = 1'b0;
`endif
  end

endmodule
